trig_lut_sched: RTL

Request scheduler and quadrant-reduction controller that shares one synchronous sine lookup table (0–90°, integer degrees) among several requesters. Each requester asks for the sine or cosine of an integer angle in [0,360]. The block does the following:

- arbitrates round-robin between requesters;
- folds the angle into the first quadrant;
- drives a single LUT read;
- applies the quadrant sign;
- returns a tagged 32-bit result.

It sits between the trig-consuming units and the shared sine LUT, so only one LUT instance is needed per cluster.

---
 rtl/trig_lut_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/trig_lut_sched.sv
// Round-robin scheduler sharing one first-quadrant sine LUT among NREQ requesters.
// Folds sine/cosine requests into 0..90 degrees, applies the quadrant sign and returns tagged results.
module trig_lut_sched #(
  parameter int NREQ    = 4,
  parameter int LUT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0] req_angle,
  output logic               lut_en,
  output logic [31:0]        lut_addr,
  input  logic [31:0]        lut_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_id,
  output logic [31:0]        rsp_value,
  output logic               rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      ptr_reg, ptr_next;
  logic [2:0]      id_reg, id_next;
  logic [31:0]     fold_addr_reg, fold_addr_next;
  logic            neg_reg, neg_next;
  logic            err_reg, err_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [NREQ-1:0] req_ready_reg, req_ready_next;
  logic            lut_en_reg, lut_en_next;
  logic [31:0]     lut_addr_reg, lut_addr_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [2:0]      rsp_id_reg, rsp_id_next;
  logic [31:0]     rsp_value_reg, rsp_value_next;
  logic            rsp_err_reg, rsp_err_next;

  // Requester vectors padded to 8 lanes so a 3-bit index is always in range.
  logic [7:0]  valid_pad;
  logic [7:0]  op_pad;
  logic [31:0] angle_pad [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NREQ) begin : g_used
        assign valid_pad[gi] = req_valid[gi];
        assign op_pad[gi]    = req_op[gi];
        assign angle_pad[gi] = req_angle[32*gi +: 32];
      end else begin : g_unused
        assign valid_pad[gi] = 1'b0;
        assign op_pad[gi]    = 1'b0;
        assign angle_pad[gi] = 32'd0;
      end
    end
  endgenerate

  logic       grant_found;
  logic [2:0] grant_idx;
  logic [3:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_reg} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!grant_found && valid_pad[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  logic [31:0] sel_angle, eff, fold_addr;
  logic        sel_op, fold_neg, fold_err;
  logic [7:0]  grant_onehot;

  // Cosine is sine shifted by +90; out-of-range angles are flagged and the fold is ignored.
  always_comb begin
    sel_angle = angle_pad[grant_idx];
    sel_op    = op_pad[grant_idx];
    fold_err  = sel_angle > 32'd360;
    eff       = sel_op ? sel_angle + 32'd90 : sel_angle;
    if (eff > 32'd360) eff = eff - 32'd360;
    fold_addr = eff;
    fold_neg  = 1'b0;
    if (eff <= 32'd90) begin
      fold_addr = eff;
    end else if (eff <= 32'd180) begin
      fold_addr = 32'd180 - eff;
    end else if (eff <= 32'd270) begin
      fold_addr = eff - 32'd180;
      fold_neg  = 1'b1;
    end else begin
      fold_addr = 32'd360 - eff;
      fold_neg  = 1'b1;
    end
    grant_onehot = 8'd1 << grant_idx;
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    id_next        = id_reg;
    fold_addr_next = fold_addr_reg;
    neg_next       = neg_reg;
    err_next       = err_reg;
    cnt_next       = cnt_reg;
    req_ready_next = '0;
    lut_en_next    = 1'b0;
    lut_addr_next  = lut_addr_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_id_next    = rsp_id_reg;
    rsp_value_next = rsp_value_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      ISSUE: begin
        if (err_reg) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_value_next = 32'd0;
          rsp_id_next    = id_reg;
          state_next     = RESP;
        end else begin
          lut_en_next   = 1'b1;
          lut_addr_next = fold_addr_reg;
          cnt_next      = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 3'(LUT_LAT)) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_id_next    = id_reg;
          rsp_value_next = neg_reg ? 32'd0 - lut_data : lut_data;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: ;
    endcase

    // Arbitration also runs on the handshake edge so the next grant lands right after it.
    if ((state_reg == IDLE || (state_reg == RESP && rsp_ready)) && grant_found) begin
      req_ready_next = grant_onehot[NREQ-1:0];
      ptr_next       = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
      id_next        = grant_idx;
      fold_addr_next = fold_addr;
      neg_next       = fold_neg;
      err_next       = fold_err;
      state_next     = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      fold_addr_reg <= '0;
      neg_reg       <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      req_ready_reg <= '0;
      lut_en_reg    <= 1'b0;
      lut_addr_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_value_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      id_reg        <= id_next;
      fold_addr_reg <= fold_addr_next;
      neg_reg       <= neg_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
      req_ready_reg <= req_ready_next;
      lut_en_reg    <= lut_en_next;
      lut_addr_reg  <= lut_addr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_value_reg <= rsp_value_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign req_ready = req_ready_reg;
  assign lut_en    = lut_en_reg;
  assign lut_addr  = lut_addr_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_value = rsp_value_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
